rst_seq: RTL

Parametrised reset sequencer for the clock/reset block. It qualifies system reset with PLL lock and holds all resets for a programmable settle time. It then releases the resets of up to NUM_DOM downstream clock domains in fixed order, each asserted asynchronously and deasserted synchronously in its own domain. It sits next to the PLL and replaces the fixed two-domain, two-flop reset synchronisers, adding lock-loss recovery and software-requested reset.

---
 rtl/rst_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rst_seq.sv
// rst_seq -- reset sequencer for the clock/reset block.
//
// Qualifies system reset with PLL lock, holds every reset for HOLD_CYC
// clk_sys cycles once lock is seen, then releases NUM_DOM downstream domain
// resets in index order, STAGE_GAP cycles apart. Each domain reset asserts
// asynchronously and deasserts through a SYNC_STAGES-deep synchroniser clocked
// by that domain's own clock. Lock loss and software requests re-sequence.
//
// Optional feature: define RST_LOCK_DEBOUNCE_EN to require the synchronised
// lock to stay low for 4 consecutive clk_sys cycles before it counts as a
// lock loss. Without it a single low cycle is a lock loss.
//
// Ports
//   clk_sys        sequencer clock (PLL output)
//   rst_n          async active-low reset
//   pll_locked     PLL lock, asynchronous to clk_sys
//   dom_clk        per-domain clocks
//   sw_rst_req     single-cycle clk_sys pulse: full re-sequence
//   rst_n_sys      clk_sys-domain reset, active-low
//   rst_n_dom      per-domain resets, bit i synchronous to dom_clk[i]
//   seq_busy       high whenever the sequencer is not in RUN
//   lock_loss_cnt  saturating lock-loss event count

// Per-domain deassertion synchroniser: clears asynchronously, shifts ones in.
module rst_seq_dom #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_n_i,
  output logic rst_n_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_n_o = sync_q[STAGES-1];
endmodule

module rst_seq #(
  parameter int NUM_DOM     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic [NUM_DOM-1:0] dom_clk,
  input  logic               sw_rst_req,
  output logic               rst_n_sys,
  output logic [NUM_DOM-1:0] rst_n_dom,
  output logic               seq_busy,
  output logic [7:0]         lock_loss_cnt
);
  localparam int CW = 16;

  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, HOLD = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_DOM-1:0] rel_q, rel_d;
  logic               sys_q, sys_d;
  logic [7:0]         llc_q;
  logic               llc_inc;
  logic               lock_m_q, lock_s_q;
  logic               lock_lost;

  // pll_locked synchroniser
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_locked;
      lock_s_q <= lock_m_q;
    end
  end

`ifdef RST_LOCK_DEBOUNCE_EN
  // Counts prior consecutive low cycles; the 4th low cycle qualifies the loss.
  logic [1:0] lo_cnt_q, lo_cnt_d;

  always_comb begin
    lo_cnt_d = lo_cnt_q;
    if (lock_s_q)              lo_cnt_d = '0;
    else if (lo_cnt_q != 2'd3) lo_cnt_d = lo_cnt_q + 2'd1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) lo_cnt_q <= '0;
    else        lo_cnt_q <= lo_cnt_d;
  end

  assign lock_lost = !lock_s_q && (lo_cnt_q == 2'd3);
`else
  assign lock_lost = !lock_s_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    sys_d   = sys_q;
    llc_inc = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        rel_d = '0;
        sys_d = 1'b0;
        if (lock_s_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // lock loss wins over a simultaneous end of hold
        if (lock_lost) begin
          state_d = WAIT_LOCK;
          llc_inc = 1'b1;
        end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d  = RELEASE;
          cnt_d    = '0;
          sys_d    = 1'b1;
          rel_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin // RELEASE, RUN
        if (lock_lost) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
          sys_d   = 1'b0;
          llc_inc = 1'b1;
        end else if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          rel_d   = '0;
          sys_d   = 1'b0;
        end else if (state_q == RELEASE) begin
          if (rel_q[NUM_DOM-1]) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
            for (int i = 1; i < NUM_DOM; i++)
              if (cnt_q + CW'(1) == CW'(i * STAGE_GAP)) rel_d[i] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rel_q   <= '0;
      sys_q   <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      sys_q   <= sys_d;
      if (llc_inc && llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
    end
  end

  // rel_q is a flop output; gating with rst_n makes domain assertion follow
  // rst_n immediately rather than waiting for the clk_sys flops to clear.
  logic [NUM_DOM-1:0] dom_clr_n;
  assign dom_clr_n = rel_q & {NUM_DOM{rst_n}};

  rst_seq_dom #(.STAGES(SYNC_STAGES)) u_dom [NUM_DOM-1:0] (
    .clk_i   (dom_clk),
    .clr_n_i (dom_clr_n),
    .rst_n_o (rst_n_dom)
  );

  assign rst_n_sys     = sys_q;
  assign seq_busy      = (state_q != RUN);
  assign lock_loss_cnt = llc_q;
endmodule
